param_sync_fifo: RTL and testbench

//  Single-clock, parametrised-depth FIFO for buffering operand/result rows around the systolic array.

---
 rtl/param_sync_fifo.sv | 102 ++++++++++
 tb/tb_param_sync_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy, almost flags, sticky errors and show-ahead or registered read.
// A full FIFO still accepts a push when a pop frees a slot on the same edge.
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       push,
  input  logic                       pop,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             pop_ok;
  logic             push_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop_ok)
        head <= bump(head);
      if (push_ok)
        tail <= bump(tail);
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (push && !push_ok)
        overflow <= 1'b1;
      if (pop && !pop_ok)
        underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset; on pass-through the read sees the pre-edge word.
  always_ff @(posedge clk) begin
    if (push_ok && !clear && !rst)
      mem[tail] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_show_ahead
      // Masked while empty so stale storage never leaks out after reset or clear.
      assign data_out   = empty ? '0 : mem[head];
      assign data_valid = !empty;
    end else begin : g_registered
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out   <= '0;
          data_valid <= 1'b0;
        end else if (clear) begin
          data_valid <= 1'b0;
        end else begin
          data_valid <= pop_ok;
          if (pop_ok)
            data_out <= mem[head];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives three FIFO configurations with shared stimulus and checks each against a queue-level model.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       push;
  logic       pop;
  logic [7:0] din;

  always #5 clk = ~clk;

  logic [7:0] dout0, dout1, dout2;
  logic [3:0] cnt0, cnt2;
  logic [2:0] cnt1;
  logic [2:0] dv_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [7:0] dout_a [3];
  logic [3:0] cnt_a  [3];

  always_comb begin
    dout_a[0] = dout0;
    dout_a[1] = dout1;
    dout_a[2] = dout2;
    cnt_a[0]  = cnt0;
    cnt_a[1]  = {1'b0, cnt1};
    cnt_a[2]  = cnt2;
  end

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .data_in(din), .push(push), .pop(pop),
    .data_out(dout0), .data_valid(dv_a[0]), .full(full_a[0]), .empty(empty_a[0]),
    .almost_full(af_a[0]), .almost_empty(ae_a[0]), .count(cnt0),
    .overflow(ovf_a[0]), .underflow(unf_a[0]));

  param_sync_fifo #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .data_in(din), .push(push), .pop(pop),
    .data_out(dout1), .data_valid(dv_a[1]), .full(full_a[1]), .empty(empty_a[1]),
    .almost_full(af_a[1]), .almost_empty(ae_a[1]), .count(cnt1),
    .overflow(ovf_a[1]), .underflow(unf_a[1]));

  param_sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(0), .FWFT(0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .data_in(din), .push(push), .pop(pop),
    .data_out(dout2), .data_valid(dv_a[2]), .full(full_a[2]), .empty(empty_a[2]),
    .almost_full(af_a[2]), .almost_empty(ae_a[2]), .count(cnt2),
    .overflow(ovf_a[2]), .underflow(unf_a[2]));

  function automatic int dep(input int i);
    return (i == 1) ? 5 : 8;
  endfunction
  function automatic int afl(input int i);
    return (i == 0) ? 6 : ((i == 1) ? 4 : 7);
  endfunction
  function automatic int ael(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 0);
  endfunction
  function automatic bit fw(input int i);
    return i != 2;
  endfunction

  // Model: a circular list of words per instance, plus the error flags and registered read state.
  logic [7:0] mm  [3][8];
  int         hd  [3];
  int         nn  [3];
  logic [7:0] mdo [3];
  bit         movf [3];
  bit         munf [3];
  bit         mdv  [3];

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0; nn[i] = 0; mdo[i] = 8'h00;
      movf[i] = 1'b0; munf[i] = 1'b0; mdv[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit pok, puk;
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        hd[i] = 0; nn[i] = 0;
        movf[i] = 1'b0; munf[i] = 1'b0; mdv[i] = 1'b0;
      end else begin
        pok = pop && (nn[i] > 0);
        puk = push && ((nn[i] < dep(i)) || pok);
        if (pop && !pok) munf[i] = 1'b1;
        if (push && !puk) movf[i] = 1'b1;
        mdv[i] = pok;
        if (pok) begin
          mdo[i] = mm[i][hd[i]];
          hd[i]  = (hd[i] + 1) % dep(i);
          nn[i]--;
        end
        if (puk) begin
          mm[i][(hd[i] + nn[i]) % dep(i)] = din;
          nn[i]++;
        end
      end
    end
  endtask

  function automatic int exp_do(input int i);
    if (fw(i)) return (nn[i] > 0) ? int'(mm[i][hd[i]]) : 0;
    return int'(mdo[i]);
  endfunction
  function automatic int exp_dv(input int i);
    if (fw(i)) return (nn[i] > 0) ? 1 : 0;
    return int'(mdv[i]);
  endfunction

  // Per-cycle comparison of every output of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.count", i), int'(cnt_a[i]), nn[i]);
        chk($sformatf("u%0d.empty", i), int'(empty_a[i]), (nn[i] == 0) ? 1 : 0);
        chk($sformatf("u%0d.full", i), int'(full_a[i]), (nn[i] == dep(i)) ? 1 : 0);
        chk($sformatf("u%0d.almost_full", i), int'(af_a[i]), (nn[i] >= afl(i)) ? 1 : 0);
        chk($sformatf("u%0d.almost_empty", i), int'(ae_a[i]), (nn[i] <= ael(i)) ? 1 : 0);
        chk($sformatf("u%0d.overflow", i), int'(ovf_a[i]), int'(movf[i]));
        chk($sformatf("u%0d.underflow", i), int'(unf_a[i]), int'(munf[i]));
        chk($sformatf("u%0d.data_valid", i), int'(dv_a[i]), exp_dv(i));
        chk($sformatf("u%0d.data_out", i), int'(dout_a[i]), exp_do(i));
      end
    end
  end

  // One clock of stimulus; returns just after the edge with outputs settled.
  task automatic step(input bit ps, input bit pp, input bit cl, input logic [7:0] d);
    @(negedge clk);
    #2;
    push = ps; pop = pp; clear = cl; din = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.u0.count", int'(cnt0), 0);
    chk("rst.u0.empty", int'(empty_a[0]), 1);
    chk("rst.u0.full", int'(full_a[0]), 0);
    chk("rst.u0.almost_empty", int'(ae_a[0]), 1);
    chk("rst.u1.overflow", int'(ovf_a[1]), 0);
    chk("rst.u2.data_valid", int'(dv_a[2]), 0);
    chk("rst.u2.data_out", int'(dout2), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] exp_seq [8];

  initial begin
    rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Fill DEPTH=8 with 0x10..0x17; almost_full rises at the sixth word.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h10 + k));
      if (k == 4) chk("fill.af_at5", int'(af_a[0]), 0);
      if (k == 5) chk("fill.af_at6", int'(af_a[0]), 1);
    end
    chk("fill.count", int'(cnt0), 8);
    chk("fill.full", int'(full_a[0]), 1);
    chk("fill.u1_count", int'(cnt1), 5);
    chk("fill.u1_overflow", int'(ovf_a[1]), 1);

    // Pass-through on full.
    chk("pt.head_before", int'(dout0), 8'h10);
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("pt.count", int'(cnt0), 8);
    chk("pt.overflow", int'(ovf_a[0]), 0);
    chk("pt.u2_data", int'(dout2), 8'h10);
    chk("pt.u2_valid", int'(dv_a[2]), 1);

    step(1'b1, 1'b0, 1'b0, 8'h99);
    chk("ovf.flag", int'(ovf_a[0]), 1);
    chk("ovf.count", int'(cnt0), 8);

    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain.word%0d", k), int'(dout0), int'(exp_seq[k]));
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("drain.empty", int'(empty_a[0]), 1);
    chk("drain.u2_last", int'(dout2), 8'h55);

    // Push plus pop on empty.
    step(1'b1, 1'b1, 1'b0, 8'h33);
    chk("ec.underflow", int'(unf_a[0]), 1);
    chk("ec.count", int'(cnt0), 1);
    chk("ec.fwft_data", int'(dout0), 8'h33);
    chk("ec.u2_novalid", int'(dv_a[2]), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("ec.u2_data", int'(dout2), 8'h33);
    chk("ec.u2_valid", int'(dv_a[2]), 1);

    // Clear beats simultaneous push and pop.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + k));
    chk("clr.count_before", int'(cnt0), 4);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    chk("clr.count", int'(cnt0), 0);
    chk("clr.empty", int'(empty_a[0]), 1);
    chk("clr.underflow", int'(unf_a[0]), 0);
    chk("clr.u1_overflow", int'(ovf_a[1]), 0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("clr.nowrite", int'(cnt0), 0);

    // Pointer wrap on DEPTH=5.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 8'(k + 1));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'(8'hA0 + k));
    chk("wrap.count", int'(cnt1), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap.word%0d", k), int'(dout1), 8'hA0 + k);
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end

    // Random traffic with occasional clears and one asynchronous reset mid-stream.
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) async_reset();
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2, 8'($urandom));
    end
    async_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
